// File: rtl/cell_plotter.sv
// cell_plotter: turns one grid-cell draw request (or a clear-screen request)
// into a raster burst of single-pixel writes for a 160x120 VGA frame buffer.
//
// Handshake: a request (req_valid, or clear_req) is taken on the rising clk
// edge where it is high and req_ready is high. req_ready is a registered
// output that is high only in IDLE. clear_req wins over req_valid on the same
// edge. Request fields are latched on that edge. Requests seen while busy are
// ignored, not queued. done pulses for one cycle when a transaction finishes.
//
// Every output is registered. Each cycle's outputs are computed from the next
// state, so the first pixel shows on the edge that accepts the request.
module cell_plotter #(
  parameter int          CELL_W    = 4,
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_cell_x,
  input  logic [4:0] req_cell_y,
  input  logic [2:0] req_colour,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CELL  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Pixel origin of the current burst, at full width (0,0 for a clear).
  logic [15:0] base_x_q, base_x_d;
  logic [15:0] base_y_q, base_y_d;

  // Offset of the pixel currently on the outputs, relative to the origin.
  logic [15:0] dx_q, dx_d;
  logic [15:0] dy_q, dy_d;

  // Colour latched at acceptance.
  logic [2:0]  lat_colour_q, lat_colour_d;

  // Registered outputs.
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  // Wrap limits for the pixel counters in the current mode.
  logic [15:0] lim_x, lim_y;
  logic        last_pix;
  logic        cell_in_range;

  assign req_ready = ready_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  // Wrap limits depend on mode; the final pixel is where both counters sit at their limits.
  always_comb begin
    if (state_q == S_CLEAR) begin
      lim_x = 16'(SCREEN_W - 1);
      lim_y = 16'(SCREEN_H - 1);
    end else begin
      lim_x = 16'(CELL_W - 1);
      lim_y = 16'(CELL_W - 1);
    end
    last_pix      = (dx_q == lim_x) && (dy_q == lim_y);
    cell_in_range = ({10'b0, req_cell_x} < 16'(GRID_W)) &&
                    ({11'b0, req_cell_y} < 16'(GRID_H));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    lat_colour_d = lat_colour_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          // Clear sweeps the whole screen from (0,0), x innermost.
          state_d      = S_CLEAR;
          base_x_d     = 16'd0;
          base_y_d     = 16'd0;
          dx_d         = 16'd0;
          dy_d         = 16'd0;
          lat_colour_d = BG_COLOUR;
          x_d          = 8'd0;
          y_d          = 7'd0;
          colour_d     = BG_COLOUR;
          plot_d       = 1'b1;
        end else if (req_valid) begin
          lat_colour_d = req_colour;
          if (cell_in_range) begin
            state_d  = S_CELL;
            base_x_d = 16'({10'b0, req_cell_x}) * 16'(CELL_W);
            base_y_d = 16'({11'b0, req_cell_y}) * 16'(CELL_W);
            dx_d     = 16'd0;
            dy_d     = 16'd0;
            x_d      = 8'(base_x_d);
            y_d      = 7'(base_y_d);
            colour_d = req_colour;
            plot_d   = 1'b1;
          end else begin
            // Off-grid cell: consumed without drawing anything.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_CELL, S_CLEAR: begin
        if (last_pix) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (dx_q == lim_x) begin
            dx_d = 16'd0;
            dy_d = dy_q + 16'd1;
          end else begin
            dx_d = dx_q + 16'd1;
          end
          x_d      = 8'(base_x_q + dx_d);
          y_d      = 7'(base_y_q + dy_d);
          colour_d = lat_colour_q;
          plot_d   = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      base_x_q     <= 16'd0;
      base_y_q     <= 16'd0;
      dx_q         <= 16'd0;
      dy_q         <= 16'd0;
      lat_colour_q <= 3'd0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      lat_colour_q <= lat_colour_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

endmodule
